// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants, state encoding and address split helpers for the icache refill controller
//
// Default geometry: 32-bit byte addresses, 4 words per line, 64 sets.
// Address layout: {tag, index, word-in-line, byte-in-word}.
package icache_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_SETS       = 64;

    localparam int DEF_WORD_W = $clog2(DEF_LINE_WORDS);
    localparam int DEF_OFF_W  = DEF_WORD_W + 2;
    localparam int DEF_IDX_W  = $clog2(DEF_SETS);
    localparam int DEF_TAG_W  = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        TAGWR = 2'd2,
        FLUSH = 2'd3
    } state_e;

    function automatic logic [DEF_TAG_W-1:0] tag_of(input logic [DEF_ADDR_W-1:0] addr);
        return addr[DEF_ADDR_W-1 -: DEF_TAG_W];
    endfunction

    function automatic logic [DEF_IDX_W-1:0] idx_of(input logic [DEF_ADDR_W-1:0] addr);
        return addr[DEF_OFF_W +: DEF_IDX_W];
    endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - miss refill and whole-cache flush sequencer for a direct-mapped icache
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pc, pc_valid, hit     fetch lookup and its tag-compare result
//   flush                 single-cycle request to invalidate every set
//   stall                 fetch must hold pc (combinational)
//   mem_req/addr/ack/rdata  word-at-a-time line read from main memory
//   data_we/idx/word/wdata  data array write port
//   tag_we/idx/wdata/valid  tag+valid array write port
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int SETS       = DEF_SETS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_W-1:0]             pc,
    input  logic                          pc_valid,
    input  logic                          hit,
    input  logic                          flush,
    output logic                          stall,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ack,
    input  logic [31:0]                   mem_rdata,
    output logic                          data_we,
    output logic [$clog2(SETS)-1:0]       data_idx,
    output logic [$clog2(LINE_WORDS)-1:0] data_word,
    output logic [31:0]                   data_wdata,
    output logic                          tag_we,
    output logic [$clog2(SETS)-1:0]       tag_idx,
    output logic [ADDR_W-$clog2(SETS)-$clog2(LINE_WORDS)-3:0] tag_wdata,
    output logic                          tag_valid
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = ADDR_W - OFF_W;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  beat_q, beat_d;
    logic [IDX_W-1:0]   set_q, set_d;
    logic               flush_pend_q, flush_pend_d;
    // Line address of the miss being refilled: {tag, index}.
    logic [LINE_W-1:0]  line_q, line_d;

    logic miss;
    logic pc_unused;

    assign miss      = pc_valid & ~hit;
    assign pc_unused = ^pc[OFF_W-1:0];

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        set_d        = set_q;
        flush_pend_d = flush_pend_q;
        line_d       = line_q;
        case (state_q)
            IDLE: begin
                // A flush, new or deferred, wins over a same-cycle miss.
                if (flush || flush_pend_q) begin
                    state_d = FLUSH;
                    set_d   = '0;
                end else if (miss) begin
                    line_d  = pc[ADDR_W-1:OFF_W];
                    beat_d  = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_ack) begin
                    beat_d = beat_q + 1'b1;
                    if (&beat_q) state_d = TAGWR;
                end
            end
            TAGWR: begin
                if (flush) flush_pend_d = 1'b1;
                state_d = IDLE;
            end
            FLUSH: begin
                // Flush pulses here are dropped: the walk is already covering every set.
                set_d = set_q + 1'b1;
                if (&set_q) begin
                    state_d      = IDLE;
                    flush_pend_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            set_q        <= '0;
            flush_pend_q <= 1'b0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            set_q        <= set_d;
            flush_pend_q <= flush_pend_d;
            line_q       <= line_d;
        end
    end

    assign stall    = (state_q != IDLE) | miss | flush_pend_q;

    assign mem_req  = (state_q == FILL);
    assign mem_addr = {line_q, beat_q, 2'b00};

    assign data_we    = (state_q == FILL) & mem_ack;
    assign data_idx   = line_q[IDX_W-1:0];
    assign data_word  = beat_q;
    assign data_wdata = (state_q == FILL) ? mem_rdata : 32'd0;

    // Tag port is shared: the refilled line's tag in TAGWR, clearing writes during the flush walk.
    assign tag_we    = (state_q == TAGWR) | (state_q == FLUSH);
    assign tag_idx   = (state_q == FLUSH) ? set_q : line_q[IDX_W-1:0];
    assign tag_wdata = (state_q == TAGWR) ? line_q[LINE_W-1 -: TAG_W] : '0;
    assign tag_valid = (state_q == TAGWR);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - scoreboard bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_valid;
    logic        hit;
    logic        flush;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        data_we;
    logic [5:0]  data_idx;
    logic [1:0]  data_word;
    logic [31:0] data_wdata;
    logic        tag_we;
    logic [5:0]  tag_idx;
    logic [21:0] tag_wdata;
    logic        tag_valid;

    icache_refill_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .hit        (hit),
        .flush      (flush),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .data_we    (data_we),
        .data_idx   (data_idx),
        .data_word  (data_word),
        .data_wdata (data_wdata),
        .tag_we     (tag_we),
        .tag_idx    (tag_idx),
        .tag_wdata  (tag_wdata),
        .tag_valid  (tag_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  idx;
        logic [1:0]  word;
        logic [31:0] wdata;
    } dexp_t;

    typedef struct packed {
        logic [5:0]  idx;
        logic [21:0] tag;
        logic        valid;
    } texp_t;

    logic [31:0] exp_addr_q[$];
    dexp_t       exp_data_q[$];
    texp_t       exp_tag_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int stall_cnt = 0, stall_rise = 0, req_cnt = 0;
    int dwe_cnt = 0, twe_cnt = 0;
    int first_dwe = 0, last_dwe = 0, first_twe = 0, last_twe = 0;
    logic        prev_stall = 1'b0;
    logic        prev_req_wait = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    int ack_lat = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected DUT activity at cycle %0d", name, cyc);
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic push_line(input logic [31:0] base, input logic [5:0] idx, input logic [21:0] tag);
        for (int w = 0; w < 4; w++) begin
            exp_addr_q.push_back(base + 32'(w * 4));
            exp_data_q.push_back('{idx: idx, word: 2'(w), wdata: rdata_of(base + 32'(w * 4))});
        end
        exp_tag_q.push_back('{idx: idx, tag: tag, valid: 1'b1});
    endtask

    task automatic push_flush();
        for (int s = 0; s < 64; s++) exp_tag_q.push_back('{idx: 6'(s), tag: 22'd0, valid: 1'b0});
    endtask

    task automatic clear_counters();
        stall_cnt = 0; stall_rise = 0; req_cnt = 0;
        dwe_cnt = 0; twe_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dwe(input int target, input int budget, input string name);
        for (int i = 0; i < budget && dwe_cnt < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (dwe_cnt < target) check(name, 64'(dwe_cnt), 64'(target));
    endtask

    task automatic wait_twe(input int target, input int budget, input string name);
        for (int i = 0; i < budget && twe_cnt < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (twe_cnt < target) check(name, 64'(twe_cnt), 64'(target));
    endtask

    // Memory model: each beat is acked after ack_lat idle cycles of mem_req,
    // so a beat occupies ack_lat+1 cycles of FILL.
    initial begin
        int wait_c;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        wait_c    = 0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req) begin
                if (wait_c >= ack_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata_of(mem_addr);
                    wait_c    = 0;
                end else begin
                    mem_ack = 1'b0;
                    wait_c++;
                end
            end else begin
                mem_ack = 1'b0;
                wait_c  = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a transfer.
    always @(negedge clk) begin
        cyc++;
        if (stall) stall_cnt++;
        if (stall && !prev_stall) stall_rise++;
        prev_stall = stall;
        if (mem_req) req_cnt++;
        if (mem_req && prev_req_wait) check("mem_addr_hold", mem_addr, prev_addr);
        prev_req_wait = mem_req && !mem_ack;
        prev_addr     = mem_addr;
        if (mem_req && mem_ack) begin
            if (exp_addr_q.size() == 0) fail_now("unexpected_mem_ack");
            else check("mem_addr", mem_addr, exp_addr_q.pop_front());
        end
        if (data_we) begin
            if (dwe_cnt == 0) first_dwe = cyc;
            last_dwe = cyc;
            dwe_cnt++;
            if (exp_data_q.size() == 0) fail_now("unexpected_data_we");
            else check("data_write", {data_idx, data_word, data_wdata}, exp_data_q.pop_front());
        end
        if (tag_we) begin
            if (twe_cnt == 0) first_twe = cyc;
            last_twe = cyc;
            twe_cnt++;
            if (exp_tag_q.size() == 0) fail_now("unexpected_tag_we");
            else check("tag_write", {tag_idx, tag_wdata, tag_valid}, exp_tag_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pc = 32'd0; pc_valid = 1'b0; hit = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", {stall, mem_req, data_we, tag_we, tag_valid}, 64'd0);
        check("reset_addr", mem_addr, 64'd0);
        check("reset_data", {data_idx, data_word, data_wdata}, 64'd0);
        check("reset_tag", {tag_idx, tag_wdata}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset after beats 0 and 1 of a fill have been acked.
        ack_lat = 1;
        clear_counters();
        exp_addr_q.push_back(32'h0000_1230);
        exp_addr_q.push_back(32'h0000_1234);
        exp_data_q.push_back('{idx: 6'h23, word: 2'd0, wdata: rdata_of(32'h0000_1230)});
        exp_data_q.push_back('{idx: 6'h23, word: 2'd1, wdata: rdata_of(32'h0000_1234)});
        pc = 32'h0000_1234; pc_valid = 1'b1; hit = 1'b0;
        wait_dwe(2, 50, "rst_mid_wait");
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid_mem_req", mem_req, 64'd0);
        check("rst_mid_stall_miss", stall, 64'd1);
        hit = 1'b1;
        #1;
        check("rst_mid_stall_hit", stall, 64'd0);
        tick();
        rst_n = 1'b1; pc_valid = 1'b0; hit = 1'b0;
        repeat (4) tick();
        check("rst_mid_no_tag_we", 64'(twe_cnt), 64'd0);
        check("rst_mid_no_req", mem_req, 64'd0);
        check("rst_mid_queue", 64'(exp_addr_q.size() + exp_data_q.size()), 64'd0);
        exp_addr_q.delete(); exp_data_q.delete();

        // Cold miss, 3 cycles per beat: stall = 1 + 12 + 1 = 14.
        ack_lat = 2;
        push_line(32'h0000_1230, 6'h23, 22'h4);
        tick();
        clear_counters();
        pc = 32'h0000_1234; pc_valid = 1'b1; hit = 1'b0;
        @(negedge clk);
        #1;
        check("miss_stall_same_cycle", stall, 64'd1);
        wait_twe(1, 100, "cold_miss_wait");
        tick();
        hit = 1'b1;
        @(negedge clk);
        #1;
        check("cold_miss_release", stall, 64'd0);
        check("cold_miss_stall_cycles", 64'(stall_cnt), 64'd14);
        check("cold_miss_queue", 64'(exp_addr_q.size() + exp_data_q.size() + exp_tag_q.size()), 64'd0);
        tick();
        pc_valid = 1'b0; hit = 1'b0;

        // Back-to-back acks: stall = 1 + 4 + 1 = 6, data writes on consecutive cycles.
        ack_lat = 0;
        push_line(32'h8000_0F00, 6'h30, 22'h200003);
        tick();
        clear_counters();
        pc = 32'h8000_0F04; pc_valid = 1'b1; hit = 1'b0;
        wait_twe(1, 50, "b2b_wait");
        tick();
        hit = 1'b1;
        @(negedge clk);
        #1;
        check("b2b_release", stall, 64'd0);
        check("b2b_stall_cycles", 64'(stall_cnt), 64'd6);
        check("b2b_data_span", 64'(last_dwe - first_dwe), 64'd3);
        check("b2b_data_count", 64'(dwe_cnt), 64'd4);
        tick();
        pc_valid = 1'b0; hit = 1'b0;

        // Hit stream: no stall, no memory traffic, no writes.
        tick();
        clear_counters();
        for (int i = 0; i < 10; i++) begin
            pc = 32'h0000_2000 + 32'(i * 4); pc_valid = 1'b1; hit = 1'b1;
            tick();
        end
        pc_valid = 1'b0; hit = 1'b0;
        check("hits_stall", 64'(stall_cnt), 64'd0);
        check("hits_req", 64'(req_cnt), 64'd0);
        check("hits_writes", 64'(dwe_cnt + twe_cnt), 64'd0);

        // Flush from IDLE: 64 consecutive clearing writes, stall for exactly 64 cycles.
        push_flush();
        tick();
        clear_counters();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_twe(64, 200, "flush_wait");
        repeat (3) tick();
        check("flush_stall_cycles", 64'(stall_cnt), 64'd64);
        check("flush_span", 64'(last_twe - first_twe), 64'd63);
        check("flush_stall_rise", 64'(stall_rise), 64'd1);
        check("flush_queue", 64'(exp_tag_q.size()), 64'd0);

        // Flush during beat 2 of a fill: 1 + 8 + 1 (TAGWR) + 1 (pending in IDLE) + 64 = 75.
        ack_lat = 1;
        push_line(32'h0000_0040, 6'h04, 22'h0);
        push_flush();
        tick();
        clear_counters();
        pc = 32'h0000_0040; pc_valid = 1'b1; hit = 1'b0;
        wait_dwe(2, 50, "fill_flush_wait_beat");
        tick();
        flush = 1'b1; pc_valid = 1'b0;
        tick();
        flush = 1'b0;
        wait_twe(65, 300, "fill_flush_wait");
        repeat (3) tick();
        check("fill_flush_stall_cycles", 64'(stall_cnt), 64'd75);
        check("fill_flush_stall_rise", 64'(stall_rise), 64'd1);
        check("fill_flush_queue", 64'(exp_addr_q.size() + exp_data_q.size() + exp_tag_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
